// File: rtl/print_uart_arbiter.sv
// Round-robin arbiter that shares one UART print engine between N_REQ requesters.
// One job at a time, a finish pulse back to the owner, and an optional watchdog on a hung UART.
module print_uart_arbiter #(
  parameter int N_REQ   = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 0
) (
  input  logic                      clk_sys_i,
  input  logic                      rst_sys_i,
  input  logic [N_REQ-1:0]          req_en_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [ADDR_W-1:0]         req_addr_o,
  output logic [N_REQ-1:0]          req_grant_o,
  output logic [N_REQ-1:0]          req_finish_o,
  output logic                      uart_start_o,
  input  logic                      uart_finish_i,
  input  logic [ADDR_W-1:0]         uart_data_addr_i,
  output logic [DATA_W-1:0]         uart_data_o,
  output logic                      busy_o,
  output logic                      timeout_o
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_next;
  logic [N_REQ-1:0]  grant, mask, eligible, pick;
  logic [IDX_W-1:0]  rr_ptr, pick_idx;
  logic [31:0]       wdog;
  logic              timed_out, expire, found;
  int                idx;

  // Round-robin search starts one past the last winner and wraps.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    eligible = req_en_i & ~mask;
    pick     = '0;
    pick_idx = rr_ptr;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % N_REQ;
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        pick[idx]   = 1'b1;
        pick_idx    = IDX_W'(idx);
      end
    end
  end

  always_comb begin
    state_next = state;
    expire     = 1'b0;
    case (state)
      IDLE: if (found) state_next = BUSY;
      BUSY: begin
        // A real finish on the expiry cycle wins over the watchdog.
        if (uart_finish_i) begin
          state_next = DONE;
        end else if (TIMEOUT != 0 && wdog == 32'(TIMEOUT - 1)) begin
          state_next = DONE;
          expire     = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= IDX_W'(N_REQ - 1);
      mask      <= '0;
      wdog      <= '0;
      timed_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      // A low enable always clears its mask bit, even on the DONE cycle that would set it.
      mask  <= (mask | ((state == DONE) ? grant : '0)) & req_en_i;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (found) begin
            grant  <= pick;
            rr_ptr <= pick_idx;
          end
        end
        BUSY: begin
          wdog      <= wdog + 32'd1;
          timed_out <= expire;
        end
        default: begin
          grant     <= '0;
          wdog      <= '0;
          timed_out <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    uart_data_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) uart_data_o = uart_data_o | req_data_i[i*DATA_W +: DATA_W];
    end
  end

  assign req_addr_o   = uart_data_addr_i;
  assign req_grant_o  = grant;
  assign req_finish_o = (state == DONE) ? grant : '0;
  assign uart_start_o = (state == BUSY);
  assign busy_o       = (state != IDLE);
  assign timeout_o    = (state == DONE) && timed_out;

endmodule
